wb_grf_stage: RTL and testbench
===============================

// Module: wb_grf_stage
// PURPOSE
// - Write-back stage downstream of the MEM/WB pipeline register. Consumes the *_Wb bundle.
// - Selects and extends the write-back value: load data, ALU result or link address.
// - Owns the 32x32 general register file (GRF), with two read ports for the decode stage.
// - Emits a registered commit record for the bench trace and for forwarding visibility.
// PARAMETERS
// - DATA_W  32  datapath width; only 32 is supported.
// - NREG    32  register count; register 0 is hardwired to zero.
// - BYPASS  1   1 = a read of the register being written this cycle returns the new value.
// PORTS
// clk         in   1   rising-edge clock
// reset       in   1   asynchronous, active-low reset (0 = reset asserted)
// pc_Wb       in   32  PC of the instruction in WB
// instr_Wb    in   32  instruction word in WB
// dmRd_Wb     in   32  raw aligned data-memory word
// aluAns_Wb   in   32  ALU result; also the effective address for loads
// grfWa_Wb    in   5   destination register
// ifWrGrf_Wb  in   1   instruction writes the GRF
// grfRa1_D    in   5   decode read address 1 (rs)
// grfRa2_D    in   5   decode read address 2 (rt)
// grfRd1_D    out  32  read data 1 (combinational)
// grfRd2_D    out  32  read data 2 (combinational)
// grfWd_Wb    out  32  selected write-back value (combinational, for forwarding)
// cmtValid    out  1   registered: a GRF write committed last cycle
// cmtPc       out  32  registered PC of that write
// cmtAddr     out  5   registered destination of that write
// cmtData     out  32  registered data of that write
// BEHAVIOUR
// - Decode: op = instr_Wb[31:26], funct = instr_Wb[5:0]; byte offset off = aluAns_Wb[1:0].
// - Write-back select:
//   - lw (0x23): dmRd_Wb.
//   - lb (0x20): sign-extend byte off. lbu (0x24): zero-extend byte off.
//   - lh (0x21): sign-extend half off[1]. lhu (0x25): zero-extend half off[1].
//   - jal (op 0x03), jalr (op 0, funct 0x09): pc_Wb + 8, wrapping modulo 2^32.
//   - all other instructions: aluAns_Wb.
// - Byte order is little-endian: byte k = dmRd[8k+7:8k]; half 1 = dmRd[31:16].
// - Misaligned lw/lh: off bits are ignored beyond the selection above; no fault is raised.
// - Write enable we = ifWrGrf_Wb && grfWa_Wb != 0.
//   - When we is high, GRF[grfWa_Wb] takes grfWd_Wb at the rising edge of clk.
//   - A write to register 0 is discarded, and cmtValid stays 0 for it.
// - Reads: grfRdN_D = 0 when grfRaN_D == 0.
//   - Else, if BYPASS && we && grfRaN_D == grfWa_Wb, the value is grfWd_Wb (same-cycle bypass).
//   - Else the value is GRF[grfRaN_D].
// - Both read ports may hit the same register as the write at once; both are bypassed.
// - Commit record: at each rising edge, cmtValid <= we.
//   - cmtPc, cmtAddr and cmtData load only when we is high, and hold otherwise.
// - Latency: write visible through the array 1 cycle after the edge; 0 cycles via bypass.
// - Reset (reset == 0, asynchronous): all GRF entries 0; cmtValid 0; cmtPc 32'h00003000;
//   cmtAddr 0; cmtData 0.
// - Reset mid-operation: a write on the same edge as reset is lost, because reset dominates.
// - After reset release, the first edge behaves normally.
// - The combinational outputs follow their inputs during reset, but read ports return 0
//   because the GRF is cleared.
// - No stall input: the stage never back-pressures; the MEM/WB register controls flow.
// STRUCTURE
// - Shared package mips_defs: opcode/funct localparams (OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU,
//   OP_JAL, OP_SPECIAL, FN_JALR), PC_RESET = 32'h00003000, and the link offset 8.
// - Sub-module grf_core: the 32x32 array with async-low reset, one write port, two bypassed
//   read ports, and a register-0 guard.
// - Load extension, write-back select and the commit register stay in the top.
// TESTING
// - Reset pulse low mid-cycle with registers holding values -> all reads 0 immediately;
//   cmtPc = 32'h00003000.
// - lw, instr op 0x23, grfWa 8, dmRd 32'hDEADBEEF -> after the edge, read $8 = DEADBEEF;
//   cmtValid 1, cmtAddr 8.
// - lb / lbu / lh / lhu with dmRd 32'h80FF7F01:
//   - lb, off 2 -> FFFFFFFF; lbu, off 3 -> 00000080.
//   - lh, off 2 -> FFFF80FF; lhu, off 0 -> 00007F01.
// - jal with pc_Wb 32'h00003010, grfWa 31 -> $31 = 32'h00003018.
//   - PC 32'hFFFFFFFC -> $31 = 32'h00000004 (wrap-around).
// - Same-cycle bypass: write $5 = 32'h12345678 while grfRa1_D = grfRa2_D = 5 -> both reads
//   return 12345678 before the edge.
// - Write to $0 with ifWrGrf 1 and ALU 32'hFFFFFFFF -> read $0 = 0, cmtValid 0.
//   - ifWrGrf 0 with grfWa 9 -> $9 unchanged; the cmt* fields hold.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS opcode/funct encodings and reset constants used by the write-back stage.
// Also decodes an instruction into the write-back source it selects.
package mips_defs;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] FN_JALR    = 6'h09;

  localparam logic [31:0] PC_RESET    = 32'h0000_3000;
  localparam logic [31:0] LINK_OFFSET = 32'd8;

  typedef enum logic [2:0] {
    WB_ALU,
    WB_WORD,
    WB_BYTE_S,
    WB_BYTE_U,
    WB_HALF_S,
    WB_HALF_U,
    WB_LINK
  } wb_sel_t;

  function automatic wb_sel_t decode_wb_sel(input logic [5:0] op, input logic [5:0] funct);
    wb_sel_t sel;
    sel = WB_ALU;
    case (op)
      OP_LW:      sel = WB_WORD;
      OP_LB:      sel = WB_BYTE_S;
      OP_LBU:     sel = WB_BYTE_U;
      OP_LH:      sel = WB_HALF_S;
      OP_LHU:     sel = WB_HALF_U;
      OP_JAL:     sel = WB_LINK;
      OP_SPECIAL: sel = (funct == FN_JALR) ? WB_LINK : WB_ALU;
      default:    sel = WB_ALU;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/grf_core.sv
// General register file: async-low cleared array, one write port, two read ports
// with optional same-cycle bypass; register 0 is never written and always reads zero.
module grf_core
  import mips_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_en;

  assign wr_en = we && (wa != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  // Each port is bypassed independently, so both may hit the write at once.
  always_comb begin
    rd1 = regs[ra1];
    if (ra1 == 5'd0) begin
      rd1 = '0;
    end else if (BYPASS && wr_en && (ra1 == wa)) begin
      rd1 = wd;
    end
  end

  always_comb begin
    rd2 = regs[ra2];
    if (ra2 == 5'd0) begin
      rd2 = '0;
    end else if (BYPASS && wr_en && (ra2 == wa)) begin
      rd2 = wd;
    end
  end

endmodule

// File: rtl/wb_grf_stage.sv
// Write-back stage: load extension, write-back select, the GRF, and a registered commit record.
// No valid/ready handshake: the stage never back-pressures; the MEM/WB register controls flow.
module wb_grf_stage
  import mips_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc_Wb,
  input  logic [31:0]       instr_Wb,
  input  logic [DATA_W-1:0] dmRd_Wb,
  input  logic [DATA_W-1:0] aluAns_Wb,
  input  logic [4:0]        grfWa_Wb,
  input  logic              ifWrGrf_Wb,
  input  logic [4:0]        grfRa1_D,
  input  logic [4:0]        grfRa2_D,
  output logic [DATA_W-1:0] grfRd1_D,
  output logic [DATA_W-1:0] grfRd2_D,
  output logic [DATA_W-1:0] grfWd_Wb,
  output logic              cmtValid,
  output logic [DATA_W-1:0] cmtPc,
  output logic [4:0]        cmtAddr,
  output logic [DATA_W-1:0] cmtData
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [1:0]  off;
  wb_sel_t     wb_sel;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        we;
  logic        unused_instr_bits;

  assign op     = instr_Wb[31:26];
  assign funct  = instr_Wb[5:0];
  assign off    = aluAns_Wb[1:0];
  assign wb_sel = decode_wb_sel(op, funct);
  assign we     = ifWrGrf_Wb && (grfWa_Wb != 5'd0);

  // Register fields and immediate do not influence write-back.
  assign unused_instr_bits = ^instr_Wb[25:6];

  // Little-endian lanes; misaligned word/half offsets are simply ignored.
  always_comb begin
    ld_byte = dmRd_Wb[7:0];
    case (off)
      2'd0: ld_byte = dmRd_Wb[7:0];
      2'd1: ld_byte = dmRd_Wb[15:8];
      2'd2: ld_byte = dmRd_Wb[23:16];
      2'd3: ld_byte = dmRd_Wb[31:24];
      default: ld_byte = dmRd_Wb[7:0];
    endcase
    ld_half = off[1] ? dmRd_Wb[31:16] : dmRd_Wb[15:0];
  end

  always_comb begin
    grfWd_Wb = aluAns_Wb;
    case (wb_sel)
      WB_WORD:   grfWd_Wb = dmRd_Wb;
      WB_BYTE_S: grfWd_Wb = {{24{ld_byte[7]}}, ld_byte};
      WB_BYTE_U: grfWd_Wb = {24'd0, ld_byte};
      WB_HALF_S: grfWd_Wb = {{16{ld_half[15]}}, ld_half};
      WB_HALF_U: grfWd_Wb = {16'd0, ld_half};
      WB_LINK:   grfWd_Wb = pc_Wb + LINK_OFFSET;
      default:   grfWd_Wb = aluAns_Wb;
    endcase
  end

  grf_core #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .BYPASS (BYPASS)
  ) u_grf (
    .clk   (clk),
    .reset (reset),
    .we    (ifWrGrf_Wb),
    .wa    (grfWa_Wb),
    .wd    (grfWd_Wb),
    .ra1   (grfRa1_D),
    .ra2   (grfRa2_D),
    .rd1   (grfRd1_D),
    .rd2   (grfRd2_D)
  );

  // Payload fields hold their last committed write while cmtValid is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmtValid <= 1'b0;
      cmtPc    <= PC_RESET;
      cmtAddr  <= 5'd0;
      cmtData  <= '0;
    end else begin
      cmtValid <= we;
      if (we) begin
        cmtPc   <= pc_Wb;
        cmtAddr <= grfWa_Wb;
        cmtData <= grfWd_Wb;
      end
    end
  end

endmodule

// File: tb/tb_wb_grf_stage.sv
// Directed bench for wb_grf_stage: a table of write-back vectors plus hand-written
// sequences for reset, register 0, disabled writes and same-cycle bypass.
module tb_wb_grf_stage;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_Wb, instr_Wb, dmRd_Wb, aluAns_Wb;
  logic [4:0]  grfWa_Wb, grfRa1_D, grfRa2_D;
  logic        ifWrGrf_Wb;
  logic [31:0] grfRd1_D, grfRd2_D, grfWd_Wb, cmtPc, cmtData;
  logic        cmtValid;
  logic [4:0]  cmtAddr;

  always #5 clk = ~clk;

  wb_grf_stage dut (
    .clk        (clk),
    .reset      (reset),
    .pc_Wb      (pc_Wb),
    .instr_Wb   (instr_Wb),
    .dmRd_Wb    (dmRd_Wb),
    .aluAns_Wb  (aluAns_Wb),
    .grfWa_Wb   (grfWa_Wb),
    .ifWrGrf_Wb (ifWrGrf_Wb),
    .grfRa1_D   (grfRa1_D),
    .grfRa2_D   (grfRa2_D),
    .grfRd1_D   (grfRd1_D),
    .grfRd2_D   (grfRd2_D),
    .grfWd_Wb   (grfWd_Wb),
    .cmtValid   (cmtValid),
    .cmtPc      (cmtPc),
    .cmtAddr    (cmtAddr),
    .cmtData    (cmtData)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_regs [32];
  logic [31:0] exp_pc;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] pc,
                       input logic [31:0] dm, input logic [31:0] alu, input logic [4:0] wa,
                       input logic wr);
    instr_Wb   = {op, 20'h0_1234, fn};
    pc_Wb      = pc;
    dmRd_Wb    = dm;
    aluAns_Wb  = alu;
    grfWa_Wb   = wa;
    ifWrGrf_Wb = wr;
  endtask

  task automatic read_ports(input logic [4:0] a1, input logic [4:0] a2);
    grfRa1_D = a1;
    grfRa2_D = a2;
  endtask

  // Commits the current inputs on the next rising edge and checks the record.
  task automatic commit_and_check(input string name, input logic exp_valid);
    @(posedge clk);
    #1;
    check({name, "_cmtValid"}, {31'd0, cmtValid}, {31'd0, exp_valid});
    if (exp_valid) begin
      exp_data = exp_q.pop_front();
      exp_pc   = pc_Wb;
      exp_addr = grfWa_Wb;
    end
    check({name, "_cmtPc"}, cmtPc, exp_pc);
    check({name, "_cmtAddr"}, {27'd0, cmtAddr}, {27'd0, exp_addr});
    check({name, "_cmtData"}, cmtData, exp_data);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] pc;
    logic [31:0] dm;
    logic [31:0] alu;
    logic [4:0]  wa;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [16];

  initial begin
    vecs[0]  = '{"lb_off2",     6'h20, 6'h00, 32'h0000_3100, 32'h80FF7F01, 32'h0000_1002, 5'd10, 32'hFFFF_FFFF};
    vecs[1]  = '{"lbu_off3",    6'h24, 6'h00, 32'h0000_3104, 32'h80FF7F01, 32'h0000_1003, 5'd11, 32'h0000_0080};
    vecs[2]  = '{"lh_off2",     6'h21, 6'h00, 32'h0000_3108, 32'h80FF7F01, 32'h0000_1002, 5'd12, 32'hFFFF_80FF};
    vecs[3]  = '{"lhu_off0",    6'h25, 6'h00, 32'h0000_310C, 32'h80FF7F01, 32'h0000_1000, 5'd13, 32'h0000_7F01};
    vecs[4]  = '{"lb_off1",     6'h20, 6'h00, 32'h0000_3110, 32'h80FF7F01, 32'h0000_1001, 5'd14, 32'h0000_007F};
    vecs[5]  = '{"lb_off0",     6'h20, 6'h00, 32'h0000_3114, 32'h80FF7F01, 32'h0000_1000, 5'd15, 32'h0000_0001};
    vecs[6]  = '{"lbu_off2",    6'h24, 6'h00, 32'h0000_3118, 32'h80FF7F01, 32'h0000_1006, 5'd16, 32'h0000_00FF};
    vecs[7]  = '{"lh_off0",     6'h21, 6'h00, 32'h0000_311C, 32'h80FF7F01, 32'h0000_1004, 5'd17, 32'h0000_7F01};
    vecs[8]  = '{"lhu_off3",    6'h25, 6'h00, 32'h0000_3120, 32'h80FF7F01, 32'h0000_1003, 5'd18, 32'h0000_80FF};
    vecs[9]  = '{"lw_misalign", 6'h23, 6'h00, 32'h0000_3124, 32'h80FF7F01, 32'h0000_1001, 5'd19, 32'h80FF_7F01};
    vecs[10] = '{"jal",         6'h03, 6'h00, 32'h0000_3010, 32'h80FF7F01, 32'h0000_1234, 5'd31, 32'h0000_3018};
    vecs[11] = '{"jal_wrap",    6'h03, 6'h00, 32'hFFFF_FFFC, 32'h80FF7F01, 32'h0000_1234, 5'd31, 32'h0000_0004};
    vecs[12] = '{"jalr",        6'h00, 6'h09, 32'h0000_4000, 32'h80FF7F01, 32'h0000_0777, 5'd20, 32'h0000_4008};
    vecs[13] = '{"addu",        6'h00, 6'h21, 32'h0000_4004, 32'h80FF7F01, 32'hCAFE_F00D, 5'd21, 32'hCAFE_F00D};
    vecs[14] = '{"ori",         6'h0D, 6'h09, 32'h0000_4008, 32'h80FF7F01, 32'h0000_ABCD, 5'd22, 32'h0000_ABCD};
    vecs[15] = '{"jr_not_link", 6'h00, 6'h08, 32'h0000_400C, 32'h80FF7F01, 32'h1111_2222, 5'd23, 32'h1111_2222};
  end

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    exp_pc   = 32'h0000_3000;
    exp_addr = 5'd0;
    exp_data = 32'd0;

    reset = 1'b0;
    drive(6'h00, 6'h21, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    read_ports(5'd5, 5'd8);
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmtValid", {31'd0, cmtValid}, 32'd0);
    check("rst_cmtPc", cmtPc, 32'h0000_3000);
    check("rst_cmtAddr", {27'd0, cmtAddr}, 32'd0);
    check("rst_cmtData", cmtData, 32'd0);
    check("rst_rd1", grfRd1_D, 32'd0);
    check("rst_rd2", grfRd2_D, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // lw to $8
    @(negedge clk);
    drive(6'h23, 6'h00, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0000_2000, 5'd8, 1'b1);
    read_ports(5'd8, 5'd0);
    #1;
    check("lw_wd", grfWd_Wb, 32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    model_regs[8] = 32'hDEAD_BEEF;
    commit_and_check("lw", 1'b1);
    @(negedge clk);
    ifWrGrf_Wb = 1'b0;
    #1;
    check("lw_read8", grfRd1_D, 32'hDEAD_BEEF);

    // Table: comb select + bypass, then array read-back and commit record.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].fn, vecs[i].pc, vecs[i].dm, vecs[i].alu, vecs[i].wa, 1'b1);
      read_ports(vecs[i].wa, vecs[i].wa);
      #1;
      check({vecs[i].name, "_wd"}, grfWd_Wb, vecs[i].exp);
      check({vecs[i].name, "_byp1"}, grfRd1_D, vecs[i].exp);
      exp_q.push_back(vecs[i].exp);
      model_regs[vecs[i].wa] = vecs[i].exp;
      commit_and_check(vecs[i].name, 1'b1);
      @(negedge clk);
      ifWrGrf_Wb = 1'b0;
      #1;
      check({vecs[i].name, "_arr"}, grfRd2_D, vecs[i].exp);
    end

    // Same-cycle bypass on both ports before the edge.
    @(negedge clk);
    drive(6'h00, 6'h21, 32'h0000_5000, 32'd0, 32'h1234_5678, 5'd5, 1'b1);
    read_ports(5'd5, 5'd5);
    #1;
    check("byp_rd1", grfRd1_D, 32'h1234_5678);
    check("byp_rd2", grfRd2_D, 32'h1234_5678);
    exp_q.push_back(32'h1234_5678);
    model_regs[5] = 32'h1234_5678;
    commit_and_check("byp", 1'b1);

    // Write to $0 is discarded and does not commit.
    @(negedge clk);
    drive(6'h00, 6'h21, 32'h0000_5004, 32'd0, 32'hFFFF_FFFF, 5'd0, 1'b1);
    read_ports(5'd0, 5'd0);
    #1;
    check("r0_wd", grfWd_Wb, 32'hFFFF_FFFF);
    check("r0_byp", grfRd1_D, 32'd0);
    commit_and_check("r0", 1'b0);
    check("r0_read", grfRd2_D, 32'd0);

    // Write $9, then a disabled write to $9 must not change it or the record.
    @(negedge clk);
    drive(6'h00, 6'h21, 32'h0000_5008, 32'd0, 32'hA5A5_A5A5, 5'd9, 1'b1);
    read_ports(5'd9, 5'd9);
    exp_q.push_back(32'hA5A5_A5A5);
    model_regs[9] = 32'hA5A5_A5A5;
    commit_and_check("w9", 1'b1);
    @(negedge clk);
    drive(6'h00, 6'h21, 32'h0000_500C, 32'd0, 32'h0000_0055, 5'd9, 1'b0);
    #1;
    check("nowr_nobyp", grfRd1_D, 32'hA5A5_A5A5);
    commit_and_check("nowr", 1'b0);
    check("nowr_read9", grfRd2_D, 32'hA5A5_A5A5);

    // Every register written so far still holds its last value.
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      read_ports(r[4:0], r[4:0]);
      #1;
      check($sformatf("final_r%0d", r), grfRd1_D, model_regs[r]);
    end

    // Mid-cycle async reset clears everything at once.
    @(negedge clk);
    read_ports(5'd8, 5'd5);
    #2;
    reset = 1'b0;
    #1;
    check("arst_rd1", grfRd1_D, 32'd0);
    check("arst_rd2", grfRd2_D, 32'd0);
    check("arst_cmtPc", cmtPc, 32'h0000_3000);
    check("arst_cmtValid", {31'd0, cmtValid}, 32'd0);

    // A write presented on an edge while reset is held is lost.
    drive(6'h00, 6'h21, 32'h0000_6000, 32'd0, 32'h0000_6666, 5'd6, 1'b1);
    @(posedge clk);
    #1;
    check("rstwr_cmtValid", {31'd0, cmtValid}, 32'd0);
    @(negedge clk);
    ifWrGrf_Wb = 1'b0;
    reset = 1'b1;
    read_ports(5'd6, 5'd6);
    #1;
    check("rstwr_lost", grfRd1_D, 32'd0);

    // First edge after release behaves normally.
    @(negedge clk);
    drive(6'h00, 6'h21, 32'h0000_6004, 32'd0, 32'h0000_0077, 5'd6, 1'b1);
    exp_pc   = 32'h0000_3000;
    exp_addr = 5'd0;
    exp_data = 32'd0;
    exp_q.push_back(32'h0000_0077);
    commit_and_check("post_rst", 1'b1);
    @(negedge clk);
    ifWrGrf_Wb = 1'b0;
    #1;
    check("post_rst_read6", grfRd1_D, 32'h0000_0077);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
